// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 4-bit ALU: buffers commands in a small FIFO, drives the
// ALU from registers, captures its result a cycle later and hands it downstream.
module alu_cmd_sequencer #(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] OP_MAX = 4'b1100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_cin,
    input  logic [3:0] cmd_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [3:0] alu_f,
    input  logic [7:0] alu_d,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_op,
    output logic       res_zero,
    output logic       res_err,
    output logic [7:0] op_count
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [3:0] op;
        logic       cin;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    state_t           state;
    cmd_t             head;
    logic             push;
    logic             pop;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

    // Ready and pop both look only at the registered count, so a same-cycle pop
    // never frees a slot for a push and a fresh push is not poppable until next cycle.
    assign cmd_ready = (count < FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign pop       = (count != '0) &&
                       ((state == IDLE) || ((state == DONE) && res_ready));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_cin, cmd_b, cmd_a};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_f     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: ;
                ISSUE: begin
                    res_data  <= alu_d;
                    res_op    <= alu_f;
                    res_err   <= 1'b0;
                    res_zero  <= (alu_d == 8'd0);
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        op_count  <= op_count + 8'd1;
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A pop (from IDLE or a completing DONE) overrides the next-state chosen above.
            if (pop) begin
                if (op_legal(head.op)) begin
                    alu_a   <= head.a;
                    alu_b   <= head.b;
                    alu_cin <= head.cin;
                    alu_f   <= head.op;
                    state   <= ISSUE;
                end else begin
                    res_data  <= 8'd0;
                    res_op    <= head.op;
                    res_err   <= 1'b1;
                    res_zero  <= 1'b1;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: acts as the ALU, runs directed scenarios with literal
// expectations, then random traffic against a queue-based occupancy model.
module tb_alu_cmd_sequencer;

    localparam int         DEPTH  = 4;
    localparam logic [3:0] OP_MAX = 4'b1100;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_cin;
    logic [3:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_cin;
    logic [3:0] alu_f;
    logic [7:0] alu_d;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [3:0] res_op;
    logic       res_zero;
    logic       res_err;
    logic [7:0] op_count;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .OP_MAX(OP_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_f(alu_f),
        .alu_d(alu_d),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_zero(res_zero), .res_err(res_err),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic c, input logic [3:0] f);
        logic [7:0] x, y, z;
        x = {4'b0, a};
        y = {4'b0, b};
        z = {7'b0, c};
        case (f)
            4'd0:    return x;
            4'd1:    return x - y;
            4'd2:    return x + y + z;
            4'd3:    return x - y - z;
            4'd4:    return x & y;
            4'd5:    return x | y;
            4'd6:    return x ^ y;
            4'd7:    return x * y;
            4'd8:    return (b == 4'd0) ? 8'h00 : x / y;
            4'd9:    return (b == 4'd0) ? 8'h00 : x % y;
            4'd10:   return x << 1;
            4'd11:   return {4'b0, ~a};
            4'd12:   return x + 8'd1;
            default: return 8'hEE;
        endcase
    endfunction

    always_comb alu_d = alu_fn(alu_a, alu_b, alu_cin, alu_f);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting commands plus one slot that is either empty,
    // waiting on the ALU, or presenting a result.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] op;
    } cmd_s;

    cmd_s       mq[$];
    cmd_s       m_c;
    int         m_phase = 0;
    int         m_old;
    bit         m_push;
    bit         m_take;
    logic [3:0] m_a = 0, m_b = 0, m_f = 0;
    logic       m_cin = 0;
    logic       m_valid = 0;
    logic [7:0] m_data = 0;
    logic [3:0] m_op = 0;
    logic       m_zero = 0, m_err = 0;
    logic [7:0] m_cnt = 0;

    task automatic model_clear();
        mq.delete();
        m_phase = 0;
        m_a = 0; m_b = 0; m_f = 0; m_cin = 0;
        m_valid = 0; m_data = 0; m_op = 0; m_zero = 0; m_err = 0; m_cnt = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            m_push = cmd_valid && (mq.size() < DEPTH);
            m_take = (mq.size() > 0);
            m_old  = m_phase;
            if (m_old == 1) begin
                m_data  = alu_fn(m_a, m_b, m_cin, m_f);
                m_op    = m_f;
                m_zero  = (m_data == 8'd0);
                m_err   = 0;
                m_valid = 1;
                m_phase = 2;
            end
            if (m_old == 2 && res_ready) begin
                m_cnt   = m_cnt + 8'd1;
                m_valid = 0;
                m_phase = 0;
            end
            if ((m_old == 0 || (m_old == 2 && res_ready)) && m_take) begin
                m_c = mq.pop_front();
                if (m_c.op <= OP_MAX) begin
                    m_a = m_c.a; m_b = m_c.b; m_cin = m_c.cin; m_f = m_c.op;
                    m_phase = 1;
                end else begin
                    m_data = 0; m_op = m_c.op; m_zero = 1; m_err = 1; m_valid = 1;
                    m_phase = 2;
                end
            end
            if (m_push) mq.push_back({cmd_a, cmd_b, cmd_cin, cmd_op});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
            check("m_alu_a",     32'(alu_a),     32'(m_a));
            check("m_alu_b",     32'(alu_b),     32'(m_b));
            check("m_alu_cin",   32'(alu_cin),   32'(m_cin));
            check("m_alu_f",     32'(alu_f),     32'(m_f));
            check("m_res_valid", 32'(res_valid), 32'(m_valid));
            check("m_op_count",  32'(op_count),  32'(m_cnt));
            if (m_valid) begin
                check("m_res_data", 32'(res_data), 32'(m_data));
                check("m_res_op",   32'(res_op),   32'(m_op));
                check("m_res_zero", 32'(res_zero), 32'(m_zero));
                check("m_res_err",  32'(res_err),  32'(m_err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [3:0] op);
        cmd_a = a; cmd_b = b; cmd_cin = c; cmd_op = op; cmd_valid = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmd_op = 0;
        tick();
        check("rst alu_f",     32'(alu_f),     0);
        check("rst alu_a",     32'(alu_a),     0);
        check("rst res_valid", 32'(res_valid), 0);
        check("rst res_data",  32'(res_data),  0);
        check("rst op_count",  32'(op_count),  0);
        check("rst cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
    endtask

    logic [7:0] exp_res [5];
    bit         exp_rdy [6];
    int         got;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 0; res_ready = 0;
        cmd_a = 0; cmd_b = 0; cmd_cin = 0; cmd_op = 0;
        #2;

        // 1: add with carry
        do_reset();
        res_ready = 1;
        drive(4'd7, 4'd1, 1'b1, 4'b0010);
        tick();
        cmd_valid = 0;
        tick();
        check("t1 alu_f",     32'(alu_f), 2);
        check("t1 alu_a",     32'(alu_a), 7);
        check("t1 early vld", 32'(res_valid), 0);
        tick();
        check("t1 res_valid", 32'(res_valid), 1);
        check("t1 res_data",  32'(res_data), 32'h09);
        check("t1 res_zero",  32'(res_zero), 0);
        check("t1 res_err",   32'(res_err), 0);
        check("t1 res_op",    32'(res_op), 2);
        tick();
        check("t1 op_count",  32'(op_count), 1);

        // 2: multiply then divide, back to back
        do_reset();
        res_ready = 1;
        drive(4'd6, 4'd5, 1'b0, 4'b0111);
        tick();
        drive(4'd10, 4'd5, 1'b0, 4'b1000);
        tick();
        cmd_valid = 0;
        tick();
        check("t2 mul valid", 32'(res_valid), 1);
        check("t2 mul data",  32'(res_data), 32'h1E);
        tick();
        check("t2 gap valid", 32'(res_valid), 0);
        tick();
        check("t2 div valid", 32'(res_valid), 1);
        check("t2 div data",  32'(res_data), 32'h02);
        tick();
        check("t2 op_count",  32'(op_count), 2);

        // 3: illegal opcode after a legal issue
        do_reset();
        res_ready = 1;
        drive(4'd2, 4'd3, 1'b0, 4'b0010);
        tick();
        cmd_valid = 0;
        tick(); tick(); tick();
        drive(4'd3, 4'd3, 1'b0, 4'b1111);
        tick();
        cmd_valid = 0;
        tick();
        check("t3 res_valid", 32'(res_valid), 1);
        check("t3 res_data",  32'(res_data), 0);
        check("t3 res_err",   32'(res_err), 1);
        check("t3 res_zero",  32'(res_zero), 1);
        check("t3 res_op",    32'(res_op), 15);
        check("t3 alu_f held", 32'(alu_f), 2);
        check("t3 alu_a held", 32'(alu_a), 2);
        tick();
        check("t3 op_count",  32'(op_count), 2);

        // 4: backpressure fills the FIFO, then drain
        do_reset();
        res_ready = 0;
        exp_rdy = '{1, 1, 1, 1, 1, 0};
        exp_res = '{8'd3, 8'd8, 8'd6, 8'd3, 8'd0};
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(4'd1, 4'd2, 1'b0, 4'd2);
                1: drive(4'd3, 4'd4, 1'b1, 4'd2);
                2: drive(4'd2, 4'd3, 1'b0, 4'd7);
                3: drive(4'd9, 4'd3, 1'b0, 4'd8);
                4: drive(4'd5, 4'd5, 1'b0, 4'd1);
                default: drive(4'd1, 4'd1, 1'b0, 4'd2);
            endcase
            check($sformatf("t4 cmd_ready[%0d]", i), 32'(cmd_ready), 32'(exp_rdy[i]));
            tick();
        end
        cmd_valid = 0;
        check("t4 held valid", 32'(res_valid), 1);
        check("t4 held data",  32'(res_data), 3);
        tick(); tick();
        check("t4 still held", 32'(res_data), 3);
        check("t4 still full", 32'(cmd_ready), 0);
        res_ready = 1;
        got = 0;
        for (int i = 0; i < 40 && got < 5; i++) begin
            if (res_valid) begin
                check($sformatf("t4 drain[%0d]", got), 32'(res_data), 32'(exp_res[got]));
                got++;
            end
            tick();
            if (i == 0) check("t4 ready after pop", 32'(cmd_ready), 1);
        end
        check("t4 drained count", 32'(got), 5);
        check("t4 op_count", 32'(op_count), 5);

        // 5: subtract to zero
        do_reset();
        res_ready = 1;
        drive(4'd1, 4'd1, 1'b0, 4'b0001);
        tick();
        cmd_valid = 0;
        tick(); tick();
        check("t5 res_valid", 32'(res_valid), 1);
        check("t5 res_data",  32'(res_data), 0);
        check("t5 res_zero",  32'(res_zero), 1);
        check("t5 res_err",   32'(res_err), 0);

        // 6: reset while ISSUE with three queued
        do_reset();
        res_ready = 0;
        drive(4'd1, 4'd1, 1'b0, 4'd2); tick();
        drive(4'd2, 4'd2, 1'b0, 4'd2); tick();
        drive(4'd3, 4'd3, 1'b0, 4'd2); tick();
        drive(4'd4, 4'd4, 1'b0, 4'd2); tick();
        res_ready = 1;
        drive(4'd5, 4'd5, 1'b0, 4'd2); tick();
        cmd_valid = 0;
        res_ready = 0;
        check("t6 pre op_count", 32'(op_count), 1);
        check("t6 pre alu_a",    32'(alu_a), 2);
        check("t6 pre full",     32'(cmd_ready), 1);
        rst_n = 1'b0;
        #1;
        check("t6 async alu_a",     32'(alu_a), 0);
        check("t6 async alu_f",     32'(alu_f), 0);
        check("t6 async alu_cin",   32'(alu_cin), 0);
        check("t6 async res_valid", 32'(res_valid), 0);
        check("t6 async res_data",  32'(res_data), 0);
        check("t6 async res_op",    32'(res_op), 0);
        check("t6 async op_count",  32'(op_count), 0);
        tick();
        rst_n = 1'b1;
        res_ready = 1;
        tick();
        check("t6 cmd_ready", 32'(cmd_ready), 1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t6 no stale[%0d]", i), 32'(res_valid), 0);
            tick();
        end
        check("t6 op_count", 32'(op_count), 0);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 15));
            cmd_cin   = 1'($urandom_range(0, 1));
            cmd_op    = 4'($urandom_range(0, 15));
            res_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        cmd_valid = 0;
        res_ready = 1;
        for (int i = 0; i < 12; i++) tick();
        check("rand drained", 32'(res_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Front-end issue stage placed directly upstream of the 4-bit ALU (`Alu_4_bit`).
- Accepts ALU commands (operands, carry-in, opcode) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's a/b/cin/f inputs from registers, captures the ALU's 8-bit result one cycle later, and presents it downstream with status flags over a second valid/ready handshake.

Parameters:
DEPTH, 4, command FIFO entries (power of two, ≥2)
OP_MAX, 4'b1100, highest legal opcode; opcodes above it are illegal

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  4  operand a
cmd_b  input  4  operand b
cmd_cin  input  1  carry-in
cmd_op  input  4  ALU opcode (f)
alu_a  output  4  registered drive to ALU a
alu_b  output  4  registered drive to ALU b
alu_cin  output  1  registered drive to ALU cin
alu_f  output  4  registered drive to ALU f
alu_d  input  8  ALU combinational result
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  8  captured result
res_op  output  4  opcode that produced res_data
res_zero  output  1  res_data == 0
res_err  output  1  illegal opcode
op_count  output  8  completed-result counter

Behaviour:

Reset:
- rst_n low clears the FIFO (count = 0) and sets FSM = IDLE.
- All outputs reset to 0: alu_*, res_*, op_count.
- cmd_ready resets to 1 (reset deasserted, FIFO empty).
- Reset asserted mid-operation discards every queued and in-flight command; no result is emitted for them.

Command FIFO:
- cmd_ready = (count < DEPTH).
- Push occurs on cmd_valid && cmd_ready at a rising edge.
- When full, cmd_ready = 0; a pop in the same cycle does not enable a push that cycle.
- A pop is taken from registered state only, so a command pushed into an empty FIFO is not visible for pop until the following cycle.
- Pointers wrap modulo DEPTH.

FSM states: IDLE, ISSUE, DONE.
- IDLE: if FIFO non-empty, pop the head.
  - Legal op: load alu_a/b/cin/f from the head entry, go to ISSUE.
  - Illegal op (> OP_MAX): leave alu_* unchanged, load res_data = 0, res_op = op, res_err = 1, res_zero = 1, res_valid = 1, go to DONE.
- ISSUE: capture alu_d into res_data, set res_op = alu_f, res_err = 0, res_zero = (alu_d == 0), res_valid = 1, go to DONE.
- DONE: hold res_* stable while res_valid && !res_ready.
  - On res_ready: op_count += 1 (wraps 255 → 0) and res_valid clears.
  - In the same cycle, if FIFO non-empty, pop and proceed exactly as from IDLE (back-to-back). Otherwise go to IDLE.

Timing and holding:
- Latency: command accepted at edge N → alu_* valid after edge N+1 → res_valid high after edge N+2 (legal op, empty pipe). Illegal op: res_valid after edge N+1.
- Throughput: one legal result per 2 cycles with res_ready held high.
- alu_* hold their last issued value at all times outside an issue; the ALU is purely combinational with a one-cycle settle budget.
- res_data is the full 8-bit ALU output, unmodified; no width truncation.

Test Plan:
1. Reset, then push (a=7, b=1, cin=1, op=0010) with res_ready=1 → alu_f=0010 one cycle after accept; res_valid two cycles after accept with res_data=8'h09, res_zero=0, res_err=0; op_count=1.
2. Push multiply (a=6, b=5, op=0111) then divide (a=10, b=5, op=1000) on consecutive cycles, res_ready=1 → results 8'h1E then 8'h02 in order, two cycles apart; op_count=2.
3. Push op=4'b1111 (a=3, b=3) → res_valid one cycle after pop, res_data=0, res_err=1, res_zero=1, alu_f unchanged from the previous issue.
4. Hold res_ready=0 and offer 6 back-to-back commands → 5 accepted (1 in DONE + 4 in FIFO), cmd_ready=0 on the 6th; first result held stable. Release res_ready → all 5 results drain in order; cmd_ready returns 1 after the first pop.
5. Subtract a=1, b=1, op=0001 → res_data=8'h00, res_zero=1, res_err=0.
6. Assert rst_n low while in ISSUE with 3 commands queued → all outputs 0 asynchronously and cmd_ready=1 after release; no stale result appears afterwards; op_count=0.
